// File: rtl/grayscale_mask_writer.sv
// Streams RGB pixels from a FWFT FIFO into a mask BRAM, one 8-bit gray/binary
// value per pixel at the raster-order linear address, one pixel per cycle.
module grayscale_mask_writer #(
  parameter int          IMG_WIDTH  = 720,
  parameter int          IMG_HEIGHT = 540,
  parameter int          ADDR_W     = $clog2(IMG_WIDTH*IMG_HEIGHT),
  parameter int          MODE       = 0,
  parameter int          THRESH_EN  = 0,
  parameter logic [7:0]  THRESHOLD  = 8'd128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              abort,
  input  logic              in_empty,
  input  logic [23:0]       in_dout,
  output logic              in_rd_en,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [7:0]        out_wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_WIDTH*IMG_HEIGHT-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, next;
  logic [ADDR_W-1:0] count;
  logic              pop;
  logic [7:0]        r, g, b, gray, mask;

  assign r = in_dout[23:16];
  assign g = in_dout[15:8];
  assign b = in_dout[7:0];

  generate
    if (MODE == 0) begin : g_mean
      logic [9:0] sum;
      assign sum  = {2'b0, r} + {2'b0, g} + {2'b0, b};
      assign gray = 8'(sum / 10'd3);
    end else begin : g_luma
      // Weights sum to 256, so the top byte never exceeds 255.
      logic [15:0] wsum;
      assign wsum = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};
      assign gray = 8'(wsum >> 8);
    end
  endgenerate

  assign mask = (THRESH_EN != 0) ? ((gray >= THRESHOLD) ? 8'hFF : 8'h00) : gray;

  always_comb begin
    next = state;
    pop  = 1'b0;
    case (state)
      IDLE: if (!in_empty) next = RUN;
      RUN: begin
        if (!in_empty) begin
          pop = 1'b1;
          if (count == LAST) next = DONE;
        end
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    if (abort) begin
      next = IDLE;
      pop  = 1'b0;
    end
  end

  assign in_rd_en = pop;
  assign busy     = (state == RUN) || out_wr_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= 8'd0;
      frame_done  <= 1'b0;
    end else begin
      state      <= next;
      out_wr_en  <= pop;
      frame_done <= (state == DONE) && !abort;
      if (pop) begin
        out_wr_addr <= count;
        out_wr_data <= mask;
      end
      // Holding the counter at zero through IDLE clears it on entry to RUN.
      if (abort || state == IDLE) count <= '0;
      else if (pop)               count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_grayscale_mask_writer.sv
// Directed bench: FIFO models feed three configurations (mean, luma, mean+threshold)
// of a 4x2 writer; a negedge monitor logs writes, pops and frame_done pulses.
module tb_grayscale_mask_writer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] pix(input int k);
    logic [7:0] v;
    v = 8'(k * 10);
    return {v, v + 8'd1, v + 8'd2};
  endfunction

  // ---------------- DUT 0: mean, no threshold ----------------
  logic        abort0 = 1'b0, hold0 = 1'b0;
  logic [23:0] mem0 [0:127];
  logic [6:0]  wp0 = '0, rp0 = '0;
  logic        empty0, rd0, wr0, busy0, fd0;
  logic [23:0] dout0;
  logic [2:0]  addr0;
  logic [7:0]  data0;
  assign empty0 = (wp0 == rp0) || hold0;
  assign dout0  = mem0[rp0];
  always @(posedge clock) if (rd0) rp0 <= rp0 + 7'd1;

  grayscale_mask_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .MODE(0), .THRESH_EN(0)) u0 (
    .clock(clock), .reset(reset), .abort(abort0), .in_empty(empty0), .in_dout(dout0),
    .in_rd_en(rd0), .out_wr_en(wr0), .out_wr_addr(addr0), .out_wr_data(data0),
    .busy(busy0), .frame_done(fd0));

  task automatic push0(input logic [23:0] p);
    mem0[wp0] = p;
    wp0 = wp0 + 7'd1;
  endtask

  int wa[$], wd[$], wc[$], pc[$], fdc[$];
  int viol = 0;
  always @(negedge clock) begin
    if (wr0) begin wa.push_back(int'(addr0)); wd.push_back(int'(data0)); wc.push_back(cyc); end
    if (rd0) pc.push_back(cyc);
    if (fd0) fdc.push_back(cyc);
    if (rd0 && empty0) viol++;
  end

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete(); pc.delete(); fdc.delete();
  endtask

  // ---------------- DUT 1: luma ----------------
  logic        zero = 1'b0;
  logic [23:0] mem1 [0:15];
  logic [3:0]  wp1 = '0, rp1 = '0;
  logic        empty1, rd1, wr1, busy1, fd1;
  logic [23:0] dout1;
  logic [2:0]  addr1;
  logic [7:0]  data1;
  assign empty1 = (wp1 == rp1);
  assign dout1  = mem1[rp1];
  always @(posedge clock) if (rd1) rp1 <= rp1 + 4'd1;

  grayscale_mask_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .MODE(1), .THRESH_EN(0)) u1 (
    .clock(clock), .reset(reset), .abort(zero), .in_empty(empty1), .in_dout(dout1),
    .in_rd_en(rd1), .out_wr_en(wr1), .out_wr_addr(addr1), .out_wr_data(data1),
    .busy(busy1), .frame_done(fd1));

  int wd1[$];
  always @(negedge clock) if (wr1) wd1.push_back(int'(data1));

  // ---------------- DUT 2: mean + threshold 128 ----------------
  logic [23:0] mem2 [0:15];
  logic [3:0]  wp2 = '0, rp2 = '0;
  logic        empty2, rd2, wr2, busy2, fd2;
  logic [23:0] dout2;
  logic [2:0]  addr2;
  logic [7:0]  data2;
  assign empty2 = (wp2 == rp2);
  assign dout2  = mem2[rp2];
  always @(posedge clock) if (rd2) rp2 <= rp2 + 4'd1;

  grayscale_mask_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .MODE(0), .THRESH_EN(1),
                          .THRESHOLD(8'd128)) u2 (
    .clock(clock), .reset(reset), .abort(zero), .in_empty(empty2), .in_dout(dout2),
    .in_rd_en(rd2), .out_wr_en(wr2), .out_wr_addr(addr2), .out_wr_data(data2),
    .busy(busy2), .frame_done(fd2));

  int wd2[$];
  always @(negedge clock) if (wr2) wd2.push_back(int'(data2));

  logic [23:0] luma_px [0:4];
  logic [7:0]  luma_ex [0:4];
  logic [23:0] thr_px  [0:2];
  logic [7:0]  thr_ex  [0:2];

  initial begin
    luma_px = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000};
    luma_ex = '{8'hFF, 8'h4C, 8'h95, 8'h1C, 8'h00};
    thr_px  = '{24'h7F7F7F, 24'h808080, 24'h7F7F82};
    thr_ex  = '{8'h00, 8'hFF, 8'h00};
    thr_ex[2] = 8'hFF;  // 0x7F+0x7F+0x82 = 384, /3 = 128 -> at threshold

    // Reset state, with the FIFO already holding a full frame.
    for (int k = 0; k < 8; k++) push0(pix(k));
    #1;
    chk("rst_wr_en", wr0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", fd0, 0);
    chk("rst_rd_en", rd0, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    // Test 1: preloaded frame, back-to-back writes.
    repeat (20) @(negedge clock);
    chk("t1_nwr", wa.size(), 8);
    for (int k = 0; k < 8 && k < wa.size(); k++) begin
      chk("t1_addr", wa[k], k);
      chk("t1_data", wd[k], k * 10 + 1);
      chk("t1_consec", wc[k], wc[0] + k);
      if (k < pc.size()) chk("t1_lat", wc[k], pc[k] + 1);
    end
    chk("t1_nfd", fdc.size(), 1);
    if (fdc.size() > 0 && wc.size() == 8) chk("t1_fd_cyc", fdc[0], wc[7] + 1);
    chk("t1_busy", busy0, 0);

    // Test 2: sparse input, empty toggling every cycle.
    @(posedge clock); #1;
    clear_logs();
    hold0 = 1'b1;
    for (int k = 0; k < 8; k++) push0(pix(k));
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #2 hold0 = ~hold0;
    end
    hold0 = 1'b0;
    repeat (4) @(negedge clock);
    chk("t2_nwr", wa.size(), 8);
    for (int k = 0; k < 8 && k < wa.size() && k < pc.size(); k++) begin
      chk("t2_addr", wa[k], k);
      chk("t2_lat", wc[k], pc[k] + 1);
    end
    if (pc.size() > 1) chk("t2_gap", pc[1] - pc[0], 2);
    chk("t2_nfd", fdc.size(), 1);
    chk("t2_no_rd_empty", viol, 0);

    // Test 3: luma and threshold configurations.
    for (int k = 0; k < 5; k++) begin mem1[wp1] = luma_px[k]; wp1 = wp1 + 4'd1; end
    for (int k = 0; k < 3; k++) begin mem2[wp2] = thr_px[k]; wp2 = wp2 + 4'd1; end
    repeat (10) @(negedge clock);
    chk("t3_luma_n", wd1.size(), 5);
    for (int k = 0; k < 5 && k < wd1.size(); k++) chk("t3_luma", wd1[k], luma_ex[k]);
    chk("t3_thr_n", wd2.size(), 3);
    for (int k = 0; k < 3 && k < wd2.size(); k++) chk("t3_thr", wd2[k], thr_ex[k]);

    // Test 4: abort after 3 pops, then a full frame.
    @(posedge clock); #1;
    clear_logs();
    for (int k = 0; k < 3; k++) push0(pix(k));
    for (int i = 0; i < 20 && wa.size() < 3; i++) @(negedge clock);
    chk("t4_three", wa.size(), 3);
    @(posedge clock); #2;
    abort0 = 1'b1;
    for (int k = 0; k < 8; k++) push0(pix(k));
    #1 chk("t4_abort_rd", rd0, 0);
    @(posedge clock); #2 abort0 = 1'b0;
    chk("t4_wr_after", wr0, 0);
    chk("t4_busy_after", busy0, 0);
    repeat (20) @(negedge clock);
    chk("t4_nwr", wa.size(), 11);
    for (int k = 0; k < 11 && k < wa.size(); k++)
      chk("t4_addr", wa[k], (k < 3) ? k : k - 3);
    chk("t4_nfd", fdc.size(), 1);
    if (fdc.size() > 0 && wc.size() == 11) chk("t4_fd_cyc", fdc[0], wc[10] + 1);

    // Test 5: async reset mid-frame, then two back-to-back frames.
    @(posedge clock); #1;
    clear_logs();
    for (int k = 0; k < 8; k++) push0(pix(k));
    for (int i = 0; i < 20 && wa.size() < 5; i++) @(negedge clock);
    chk("t5_five", wa.size(), 5);
    reset = 1'b1;
    #1;
    chk("t5_rst_wr", wr0, 0);
    chk("t5_rst_addr", addr0, 0);
    chk("t5_rst_data", data0, 0);
    chk("t5_rst_busy", busy0, 0);
    chk("t5_rst_rd", rd0, 0);
    wp0 = rp0;
    @(posedge clock); #2 reset = 1'b0;
    clear_logs();
    for (int k = 0; k < 16; k++) push0(pix(k % 8));
    repeat (40) @(negedge clock);
    chk("t5_nwr", wa.size(), 16);
    for (int k = 0; k < 16 && k < wa.size(); k++) begin
      chk("t5_addr", wa[k], k % 8);
      chk("t5_data", wd[k], (k % 8) * 10 + 1);
    end
    chk("t5_nfd", fdc.size(), 2);
    if (fdc.size() == 2 && wc.size() == 16) chk("t5_fd2_cyc", fdc[1], wc[15] + 1);
    if (pc.size() == 16) chk("t5_frame_gap", pc[8] - pc[7], 3);
    chk("t5_busy", busy0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
